conv_monitor: RTL and testbench
===============================

# conv_monitor

Convergence monitor that sits directly downstream of the error stage's output register. It consumes each per-iteration error magnitude, counts iterations, and decides whether the FastICA weight update has converged, must iterate again, or has timed out. Its `next_iter` pulse is the kick that restarts the weight-update/error sequence for the next iteration. One clock domain, fully registered outputs.

## Interface
- `DATA_W`, 32: width of the unsigned error magnitude (fixed-point, same Q format as the error datapath).
- `EPS`, 32'h0000_0010: convergence threshold; an error passes when `error_in < EPS` (strict).
- `STABLE_CNT`, 3: consecutive passing iterations required to declare convergence (≥1).
- `MAX_ITER`, 1000: iteration limit; the iteration that brings `iter_count` to `MAX_ITER` is the last one.
- `ITER_W`, 16: width of the iteration counter; must hold `MAX_ITER`.

Ports:
- `clk_conv` in 1: clock; all state updates on rising edge.
- `rst_conv` in 1: asynchronous, active-high reset.
- `en_conv` in 1: level enable; 0→1 in IDLE starts a run; dropping to 0 aborts.
- `error_valid` in 1: one-cycle strobe from the error stage output; `error_in` is valid with it.
- `error_in` in DATA_W: unsigned error magnitude.
- `conv_busy` out 1: high in WAIT and CHECK.
- `next_iter` out 1: one-cycle pulse requesting the next weight-update iteration.
- `converged` out 1: sticky done flag, success.
- `timeout` out 1: sticky done flag, iteration limit hit.
- `iter_count` out ITER_W: iterations whose error has been consumed.
- `stable_count` out 3: current run of consecutive passing errors.

## Operation
- States: IDLE, WAIT, CHECK, CONV, TOUT.
- Reset: state IDLE. All outputs 0, including both counters.
- IDLE with `en_conv`=1 at an edge:
  - clear `iter_count`, `stable_count`, `converged`, `timeout`;
  - go to WAIT;
  - `next_iter`=1 for the following cycle.
- IDLE with `en_conv`=0: hold. Flags and counters keep their last values.
- WAIT with `error_valid`=1:
  - `iter_count`+1, saturating at all-ones;
  - if `error_in < EPS`, `stable_count`+1 (saturating at 7); otherwise `stable_count`←0;
  - go to CHECK.
- WAIT with `error_valid`=0: stay in WAIT.
- CHECK, exactly one cycle. Decisions are evaluated in priority order:
  1. `stable_count ≥ STABLE_CNT` → CONV, `converged`←1.
  2. `iter_count == MAX_ITER` → TOUT, `timeout`←1.
  3. Otherwise → WAIT, with `next_iter`=1 for one cycle.
- Convergence beats timeout when both hold on the same iteration.
- CONV/TOUT: `conv_busy`=0 and the flag is held. Stay until `en_conv`=0, then go to IDLE with the flag still held. The flag clears only on the next start.
- `en_conv`=0 in WAIT or CHECK: abort to IDLE.
  - `next_iter` is not issued;
  - flags stay 0;
  - counters hold their values.
- `error_valid` in IDLE, CHECK, CONV or TOUT is ignored. At most one error is consumed per `next_iter`.
- `en_conv` held at 1 after CONV/TOUT does not restart the run. A new run needs 0 then 1.

## Timing
- Start: the edge that samples `en_conv`=1 in IDLE is E0. `conv_busy` and `next_iter` are high after E0. `next_iter` falls after E1.
- Error path: `error_valid` is sampled at edge E0. Counters update after E0 and the state is CHECK during the next cycle. After E1 one of `converged`, `timeout`, or `next_iter` is high. This is a 2-edge decision latency.
- Minimum spacing between consumed errors: 2 cycles.
- `rst_conv` mid-run takes effect immediately, without a clock. All outputs go to 0. `next_iter` must not glitch high on deassertion.

## Structure
- Shared package `fastica_pkg` holds:
  - the state encoding enum;
  - the shared `DATA_W` and Q-format constants used by the error datapath.
- Single flat module; no sub-module is warranted. The comparator and counters are inline.

## Test plan
- Start with `EPS`=16, `STABLE_CNT`=3. Feed errors 40, 10, 12, 5, each answering a `next_iter`. Expect:
  - `stable_count` 0,1,2,3;
  - `converged`=1 after the 4th error, 2 edges after its strobe;
  - `iter_count`=4;
  - `next_iter` pulsed exactly 4 times in total (the start pulse plus one after each of the first 3 errors, none after the 4th).
- Pass/fail reset: feed 10, 10, 20, 10, 10, 10. Expect `stable_count` to reset to 0 at 20 and `converged` to rise on the 6th error with `iter_count`=6.
- Timeout: `MAX_ITER`=5, all errors 100. Expect `timeout`=1 and `converged`=0 after the 5th error, with no 6th `next_iter`.
- Simultaneous: `MAX_ITER`=3, `STABLE_CNT`=3, errors 1, 1, 1. Expect `converged`=1 and `timeout`=0.
- Abort and restart: drop `en_conv` in WAIT after 2 errors. Expect IDLE, `conv_busy`=0, `iter_count`=2. Re-raise `en_conv`: counters clear and `next_iter` pulses.
- Async reset asserted during CHECK: all outputs 0 immediately. After release the block stays in IDLE until an `en_conv` 0→1 start.

Source files
------------

// File: rtl/fastica_pkg.sv
// rtl/fastica_pkg.sv - shared FastICA constants and convergence-monitor state encoding
package fastica_pkg;

  localparam int DATA_W = 32;
  // Error datapath fixed-point format: Q16.16 unsigned magnitude
  localparam int Q_FRAC = 16;
  localparam int Q_INT  = DATA_W - Q_FRAC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_CONV,
    ST_TOUT
  } conv_state_t;

endpackage

// File: rtl/conv_monitor.sv
// rtl/conv_monitor.sv - FastICA convergence monitor: consumes per-iteration error,
// counts iterations and decides converge / iterate / timeout.
module conv_monitor #(
  parameter int                  DATA_W     = fastica_pkg::DATA_W,
  parameter logic [DATA_W-1:0]   EPS        = 32'h0000_0010,
  parameter int                  STABLE_CNT = 3,
  parameter int                  MAX_ITER   = 1000,
  parameter int                  ITER_W     = 16
) (
  input  logic              clk_conv,
  input  logic              rst_conv,
  input  logic              en_conv,
  input  logic              error_valid,
  input  logic [DATA_W-1:0] error_in,
  output logic              conv_busy,
  output logic              next_iter,
  output logic              converged,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count,
  output logic [2:0]        stable_count
);

  import fastica_pkg::*;

  localparam logic [2:0]        STABLE_THR = 3'(STABLE_CNT);
  localparam logic [ITER_W-1:0] ITER_MAX   = ITER_W'(MAX_ITER);

  conv_state_t       state, state_nx;
  logic              en_q;
  logic [ITER_W-1:0] iter_nx;
  logic [2:0]        stable_nx;
  logic              conv_nx, tout_nx, next_nx, busy_nx;

  always_comb begin
    state_nx  = state;
    iter_nx   = iter_count;
    stable_nx = stable_count;
    conv_nx   = converged;
    tout_nx   = timeout;
    next_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A run starts only on a 0->1 of en_conv, so a held enable never restarts
        if (en_conv && !en_q) begin
          state_nx  = ST_WAIT;
          iter_nx   = '0;
          stable_nx = '0;
          conv_nx   = 1'b0;
          tout_nx   = 1'b0;
          next_nx   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!en_conv) begin
          state_nx = ST_IDLE;
        end else if (error_valid) begin
          iter_nx = (iter_count == '1) ? iter_count : iter_count + 1'b1;
          if (error_in < EPS)
            stable_nx = (stable_count == 3'd7) ? 3'd7 : stable_count + 3'd1;
          else
            stable_nx = '0;
          state_nx = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!en_conv) begin
          state_nx = ST_IDLE;
        end else if (stable_count >= STABLE_THR) begin
          state_nx = ST_CONV;
          conv_nx  = 1'b1;
        end else if (iter_count == ITER_MAX) begin
          state_nx = ST_TOUT;
          tout_nx  = 1'b1;
        end else begin
          state_nx = ST_WAIT;
          next_nx  = 1'b1;
        end
      end
      ST_CONV, ST_TOUT: begin
        if (!en_conv) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx == ST_WAIT) || (state_nx == ST_CHECK);
  end

  always_ff @(posedge clk_conv or posedge rst_conv) begin
    if (rst_conv) begin
      state        <= ST_IDLE;
      en_q         <= 1'b1;
      conv_busy    <= 1'b0;
      next_iter    <= 1'b0;
      converged    <= 1'b0;
      timeout      <= 1'b0;
      iter_count   <= '0;
      stable_count <= '0;
    end else begin
      state        <= state_nx;
      en_q         <= en_conv;
      conv_busy    <= busy_nx;
      next_iter    <= next_nx;
      converged    <= conv_nx;
      timeout      <= tout_nx;
      iter_count   <= iter_nx;
      stable_count <= stable_nx;
    end
  end

endmodule

// File: tb/tb_conv_monitor.sv
// tb/tb_conv_monitor.sv - randomized self-checking bench for conv_monitor
// (two instances: default limit and MAX_ITER=5).
module tb_conv_monitor;

  logic        clk, rst;
  logic        en[2], ev[2];
  logic [31:0] ein[2];
  logic        busy[2], nit[2], conv[2], tout[2];
  logic [15:0] iter[2];
  logic [2:0]  stab[2];
  int          total, bad;
  int          nit_cnt[2];
  int          max_it[2];

  conv_monitor u_dut0 (
    .clk_conv(clk), .rst_conv(rst), .en_conv(en[0]), .error_valid(ev[0]),
    .error_in(ein[0]), .conv_busy(busy[0]), .next_iter(nit[0]),
    .converged(conv[0]), .timeout(tout[0]), .iter_count(iter[0]),
    .stable_count(stab[0])
  );

  conv_monitor #(.MAX_ITER(5)) u_dut1 (
    .clk_conv(clk), .rst_conv(rst), .en_conv(en[1]), .error_valid(ev[1]),
    .error_in(ein[1]), .conv_busy(busy[1]), .next_iter(nit[1]),
    .converged(conv[1]), .timeout(tout[1]), .iter_count(iter[1]),
    .stable_count(stab[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (nit[d] === 1'b1) nit_cnt[d]++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_run(input int d);
    en[d] = 1'b0;
    @(negedge clk);
    nit_cnt[d] = 0;
    en[d] = 1'b1;
    @(negedge clk);
    check_val("start_busy", busy[d], 1);
    check_val("start_nit", nit[d], 1);
    check_val("start_iter", iter[d], 0);
    check_val("start_stab", stab[d], 0);
    check_val("start_conv", conv[d], 0);
    check_val("start_tout", tout[d], 0);
  endtask

  // Expected outcome per error: run length of passing errors and iteration index
  task automatic run_errs(input int d, input int unsigned errs[$], input int abort_at);
    int stable, pulses, res;
    bit dbl;
    stable = 0; pulses = 1; res = 0;
    for (int k = 0; k < errs.size(); k++) begin
      if (k == abort_at) begin
        en[d] = 1'b0;
        @(negedge clk);
        check_val("abort_busy", busy[d], 0);
        check_val("abort_iter", iter[d], k);
        check_val("abort_nit", nit[d], 0);
        check_val("abort_conv", conv[d], 0);
        ev[d] = 1'b1; ein[d] = 0;
        @(negedge clk);
        ev[d] = 1'b0;
        check_val("idle_ignore_iter", iter[d], k);
        check_val("abort_pulses", nit_cnt[d], pulses);
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      dbl = ($urandom_range(0, 3) == 0);
      ev[d] = 1'b1; ein[d] = errs[k];
      @(negedge clk);
      if (dbl) ein[d] = 0; else ev[d] = 1'b0;
      stable = (errs[k] < 16) ? ((stable < 7) ? stable + 1 : 7) : 0;
      check_val("iter", iter[d], k + 1);
      check_val("stable", stab[d], stable);
      check_val("check_busy", busy[d], 1);
      @(negedge clk);
      ev[d] = 1'b0;
      if (stable >= 3) res = 1;
      else if (k + 1 == max_it[d]) res = 2;
      else res = 0;
      check_val("dec_conv", conv[d], int'(res == 1));
      check_val("dec_tout", tout[d], int'(res == 2));
      check_val("dec_nit", nit[d], int'(res == 0));
      check_val("dec_busy", busy[d], int'(res == 0));
      if (res != 0) break;
      pulses++;
    end
    if (res == 0) begin
      en[d] = 1'b0;
      @(negedge clk);
      check_val("drain_busy", busy[d], 0);
      return;
    end
    repeat (3) @(negedge clk);
    check_val("done_hold_busy", busy[d], 0);
    check_val("done_pulses", nit_cnt[d], pulses);
    en[d] = 1'b0;
    @(negedge clk);
    check_val("idle_conv_held", conv[d], int'(res == 1));
    check_val("idle_tout_held", tout[d], int'(res == 2));
    check_val("idle_busy", busy[d], 0);
  endtask

  initial begin
    int unsigned q[$];
    total = 0; bad = 0;
    max_it[0] = 1000; max_it[1] = 5;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; ev[d] = 1'b0; ein[d] = 0; nit_cnt[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_val("rst_busy", busy[d], 0);
      check_val("rst_nit", nit[d], 0);
      check_val("rst_conv", conv[d], 0);
      check_val("rst_tout", tout[d], 0);
      check_val("rst_iter", iter[d], 0);
      check_val("rst_stab", stab[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    q = '{40, 10, 12, 5};
    start_run(0); run_errs(0, q, -1);
    q = '{10, 10, 20, 10, 10, 10};
    start_run(0); run_errs(0, q, -1);
    q = '{100, 100, 100, 100, 100, 100};
    start_run(1); run_errs(1, q, -1);
    q = '{16, 16, 15, 15, 15};
    start_run(1); run_errs(1, q, -1);

    q = '{10, 10, 10, 10};
    start_run(0); run_errs(0, q, 2);
    start_run(0);
    q = '{1, 2, 3};
    run_errs(0, q, -1);

    // Abort while in CHECK: no next_iter must follow
    start_run(0);
    ev[0] = 1'b1; ein[0] = 50;
    @(negedge clk);
    ev[0] = 1'b0; en[0] = 1'b0;
    @(negedge clk);
    check_val("chk_abort_nit", nit[0], 0);
    check_val("chk_abort_busy", busy[0], 0);
    check_val("chk_abort_iter", iter[0], 1);

    // Async reset in CHECK
    start_run(0);
    ev[0] = 1'b1; ein[0] = 3;
    @(negedge clk);
    ev[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", busy[0], 0);
    check_val("arst_nit", nit[0], 0);
    check_val("arst_iter", iter[0], 0);
    check_val("arst_stab", stab[0], 0);
    check_val("arst_conv", conv[0], 0);
    @(negedge clk);
    rst = 1'b0;
    nit_cnt[0] = 0;
    repeat (4) @(negedge clk);
    check_val("post_rst_busy", busy[0], 0);
    check_val("post_rst_pulses", nit_cnt[0], 0);
    start_run(0);
    q = '{0, 0, 0};
    run_errs(0, q, -1);

    for (int r = 0; r < 10; r++) begin
      int dd;
      dd = r % 2;
      q.delete();
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 4))
          0: q.push_back(15);
          1: q.push_back(16);
          2: q.push_back($urandom_range(17, 5000));
          default: q.push_back($urandom_range(0, 14));
        endcase
      end
      q.push_back(0); q.push_back(0); q.push_back(0);
      start_run(dd);
      run_errs(dd, q, (r == 4) ? 1 : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
